// File: rtl/reg_target_io.sv
// reg_target_io: register-controlled target I/O channels with a power
// sequencer and a timed nRST pulse generator. Lives on the shared reg_* bus;
// the tristate pad buffers belong to the top level.
module reg_target_io #(
  parameter int         pCHANNELS    = 6,
  parameter logic [5:0] pADDR_MODE   = 6'd50,
  parameter logic [5:0] pADDR_GPIO   = 6'd51,
  parameter logic [5:0] pADDR_CTRL   = 6'd52,
  parameter logic [5:0] pADDR_PULSE  = 6'd53,
  parameter logic [5:0] pADDR_SETTLE = 6'd54
) (
  input  logic                 clk_usb,
  input  logic                 reset_i,
  input  logic [5:0]           reg_address,
  input  logic [15:0]          reg_bytecnt,
  input  logic [7:0]           reg_datai,
  output logic [7:0]           reg_datao,
  input  logic                 reg_read,
  input  logic                 reg_write,
  input  logic                 reg_addrvalid,
  input  logic [5:0]           reg_hypaddress,
  output logic [15:0]          reg_hyplen,
  input  logic [pCHANNELS-1:0] src_a_i,
  output logic [pCHANNELS-1:0] target_io_o,
  output logic [pCHANNELS-1:0] target_io_oe,
  output logic                 target_npower,
  output logic                 nrst_busy
);

  localparam int MODE_BITS  = 2 * pCHANNELS;
  localparam int MODE_BYTES = (2 * pCHANNELS + 7) / 8;
  localparam int GPIO_BYTES = (pCHANNELS + 7) / 8;

  typedef enum logic [1:0] {PWR_OFF = 2'd0, PWR_SETTLE = 2'd1, PWR_ON = 2'd2} pwr_state_t;
  typedef enum logic {PULSE_IDLE = 1'b0, PULSE_ACTIVE = 1'b1} pulse_state_t;

  logic [MODE_BITS-1:0]    mode_reg;
  logic [pCHANNELS-1:0]    gpio_reg;
  logic                    power_req_reg;
  logic [15:0]             pulse_len_reg;
  logic [15:0]             settle_reg;

  pwr_state_t              power_state, power_next;
  logic [15:0]             settle_cnt, settle_cnt_next;
  pulse_state_t            pulse_state, pulse_next;
  logic [15:0]             pulse_cnt, pulse_cnt_next;

  logic [pCHANNELS-1:0]    io_next, oe_next;
  logic [pCHANNELS-1:0]    io_reg, oe_reg;
  logic                    npower_reg;
  logic                    pulse_n_next;

  logic [8*MODE_BYTES-1:0] mode_pad;
  logic [8*GPIO_BYTES-1:0] gpio_pad;

  // Write decode; a byte index outside a register simply matches nothing.
  logic wr_en, wr_mode, wr_gpio, wr_ctrl, wr_pulse, wr_settle, pulse_start;
  assign wr_en       = reg_write & reg_addrvalid;
  assign wr_mode     = wr_en && (reg_address == pADDR_MODE);
  assign wr_gpio     = wr_en && (reg_address == pADDR_GPIO);
  assign wr_ctrl     = wr_en && (reg_address == pADDR_CTRL) && (reg_bytecnt == 16'd0);
  assign wr_pulse    = wr_en && (reg_address == pADDR_PULSE);
  assign wr_settle   = wr_en && (reg_address == pADDR_SETTLE);
  // pulse_start is an event, never stored
  assign pulse_start = wr_ctrl && reg_datai[1];

  genvar gi;

  // Mode bits: each bit belongs to one byte lane of the register.
  for (gi = 0; gi < MODE_BITS; gi++) begin : g_mode_bit
    // Byte-lane write of one mode bit
    always_ff @(posedge clk_usb) begin
      if (reset_i)
        mode_reg[gi] <= 1'b0;
      else if (wr_mode && (reg_bytecnt == 16'(gi / 8)))
        mode_reg[gi] <= reg_datai[gi % 8];
    end
  end

  for (gi = 0; gi < pCHANNELS; gi++) begin : g_gpio_bit
    // Byte-lane write of one GPIO drive bit
    always_ff @(posedge clk_usb) begin
      if (reset_i)
        gpio_reg[gi] <= 1'b1;
      else if (wr_gpio && (reg_bytecnt == 16'(gi / 8)))
        gpio_reg[gi] <= reg_datai[gi % 8];
    end
  end

  // Scalar control registers: power request, pulse length, settle delay
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      power_req_reg <= 1'b0;
      pulse_len_reg <= 16'd256;
      settle_reg    <= 16'd1000;
    end else begin
      if (wr_ctrl) power_req_reg <= reg_datai[0];
      if (wr_pulse && reg_bytecnt == 16'd0)  pulse_len_reg[7:0]  <= reg_datai;
      if (wr_pulse && reg_bytecnt == 16'd1)  pulse_len_reg[15:8] <= reg_datai;
      if (wr_settle && reg_bytecnt == 16'd0) settle_reg[7:0]     <= reg_datai;
      if (wr_settle && reg_bytecnt == 16'd1) settle_reg[15:8]    <= reg_datai;
    end
  end

  assign mode_pad = (8*MODE_BYTES)'(mode_reg);
  assign gpio_pad = (8*GPIO_BYTES)'(gpio_reg);

  // Read mux: zero unless a valid read hits one of our registers, so it can be OR-combined
  always_comb begin
    reg_datao = 8'h00;
    if (reg_read && reg_addrvalid) begin
      case (reg_address)
        pADDR_MODE:   if (reg_bytecnt < 16'(MODE_BYTES)) reg_datao = 8'(mode_pad >> {reg_bytecnt, 3'b000});
        pADDR_GPIO:   if (reg_bytecnt < 16'(GPIO_BYTES)) reg_datao = 8'(gpio_pad >> {reg_bytecnt, 3'b000});
        pADDR_CTRL:   if (reg_bytecnt == 16'd0) reg_datao = {4'b0000, power_state, nrst_busy, power_req_reg};
        pADDR_PULSE:  if (reg_bytecnt == 16'd0) reg_datao = pulse_len_reg[7:0];
                      else if (reg_bytecnt == 16'd1) reg_datao = pulse_len_reg[15:8];
        pADDR_SETTLE: if (reg_bytecnt == 16'd0) reg_datao = settle_reg[7:0];
                      else if (reg_bytecnt == 16'd1) reg_datao = settle_reg[15:8];
        default:      reg_datao = 8'h00;
      endcase
    end
  end

  // Register length lookup for the host's length query
  always_comb begin
    reg_hyplen = 16'd0;
    case (reg_hypaddress)
      pADDR_MODE:   reg_hyplen = 16'(MODE_BYTES);
      pADDR_GPIO:   reg_hyplen = 16'(GPIO_BYTES);
      pADDR_CTRL:   reg_hyplen = 16'd1;
      pADDR_PULSE:  reg_hyplen = 16'd2;
      pADDR_SETTLE: reg_hyplen = 16'd2;
      default:      reg_hyplen = 16'd0;
    endcase
  end

  // Power and pulse state registers
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      power_state <= PWR_OFF;
      settle_cnt  <= 16'd0;
      pulse_state <= PULSE_IDLE;
      pulse_cnt   <= 16'd0;
    end else begin
      power_state <= power_next;
      settle_cnt  <= settle_cnt_next;
      pulse_state <= pulse_next;
      pulse_cnt   <= pulse_cnt_next;
    end
  end

  // Power sequencer: the settle count is latched on entry, so later writes only affect the next run
  always_comb begin
    power_next      = power_state;
    settle_cnt_next = settle_cnt;
    case (power_state)
      PWR_OFF: if (power_req_reg) begin
        power_next      = PWR_SETTLE;
        settle_cnt_next = settle_reg;
      end
      PWR_SETTLE: begin
        if (!power_req_reg)          power_next = PWR_OFF;
        else if (settle_cnt == 16'd0) power_next = PWR_ON;
        else                          settle_cnt_next = settle_cnt - 16'd1;
      end
      PWR_ON:  if (!power_req_reg) power_next = PWR_OFF;
      default: power_next = PWR_OFF;
    endcase
  end

  // Pulse generator: one-shot, no retrigger; dropping out of ON aborts it on the same edge
  always_comb begin
    pulse_next     = pulse_state;
    pulse_cnt_next = pulse_cnt;
    case (pulse_state)
      PULSE_IDLE: if (pulse_start && power_state == PWR_ON) begin
        pulse_next     = PULSE_ACTIVE;
        pulse_cnt_next = (pulse_len_reg == 16'd0) ? 16'd0 : pulse_len_reg - 16'd1;
      end
      PULSE_ACTIVE: begin
        if (pulse_cnt == 16'd0) pulse_next = PULSE_IDLE;
        else                    pulse_cnt_next = pulse_cnt - 16'd1;
      end
      default: pulse_next = PULSE_IDLE;
    endcase
    if (power_next != PWR_ON) pulse_next = PULSE_IDLE;
  end

  // Pad values are built from next-state so they line up with busy/npower after the edge
  assign pulse_n_next = (pulse_next != PULSE_ACTIVE);

  for (gi = 0; gi < pCHANNELS; gi++) begin : g_chan
    logic [1:0] ch_mode;
    assign ch_mode = mode_reg[2*gi +: 2];
    assign io_next[gi] = (ch_mode == 2'd1) ? src_a_i[gi] :
                         (ch_mode == 2'd2) ? gpio_reg[gi] :
                         (ch_mode == 2'd3) ? pulse_n_next : 1'b0;
    assign oe_next[gi] = (power_next == PWR_ON) && (ch_mode != 2'd0);
  end

  // Registered pad drive, enables and power switch
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      io_reg     <= '0;
      oe_reg     <= '0;
      npower_reg <= 1'b1;
    end else begin
      io_reg     <= io_next;
      oe_reg     <= oe_next;
      npower_reg <= (power_next == PWR_OFF);
    end
  end

  assign target_io_o   = io_reg;
  assign target_io_oe  = oe_reg;
  assign target_npower = npower_reg;
  assign nrst_busy     = (pulse_state == PULSE_ACTIVE);

endmodule
